serv_bus_arbiter: RTL and testbench

Two-to-one bus arbiter that sits directly downstream of the SERV core (`serv_rf_top`). It merges the core's instruction bus (read-only) and data bus into one Wishbone-classic master port toward memory and peripherals. It adds round-robin arbitration, a bus watchdog, and error termination, so that a missing or failing slave turns into a defined response instead of a core hang.

---
 rtl/serv_bus_pkg.sv | 7 +
 rtl/serv_bus_wdog.sv | 26 ++
 rtl/serv_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_serv_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serv_bus_pkg.sv
// Shared types and constants for the SERV ibus/dbus to Wishbone arbiter.
package serv_bus_pkg;
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} arb_state_t;

    localparam logic [31:0] SERV_BUS_ERR_RDT = 32'h0000_0000;
    localparam int          DEF_TIMEOUT      = 255;
endpackage

// File: rtl/serv_bus_wdog.sv
// Bus watchdog: counts granted cycles from 1 and flags when TIMEOUT is reached.
module serv_bus_wdog
    import serv_bus_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic i_rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (i_rst || clr)
            count <= '0;
        else if (en && count != LIMIT)
            count <= count + 1'b1;
    end

    assign expired = (count == LIMIT);
endmodule

// File: rtl/serv_bus_arbiter.sv
// Round-robin merge of SERV ibus and dbus onto one Wishbone-classic master,
// with watchdog and error termination so a dead slave never hangs the core.
module serv_bus_arbiter
    import serv_bus_pkg::*;
#(
    parameter int          TIMEOUT = DEF_TIMEOUT,
    parameter logic [31:0] ERR_RDT = SERV_BUS_ERR_RDT
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    output logic        o_timeout,
    output logic [7:0]  o_err_cnt
);
    arb_state_t  state, state_d;
    logic        last_d;   // 1: dbus was granted most recently
    logic        grant_i, grant_d, fin_ack, fin_err, fin_to, fin;
    logic        expired, wd_clr;
    logic [31:0] rdt;

    serv_bus_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .i_rst   (i_rst),
        .clr     (wd_clr),
        .en      (!wd_clr),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        grant_i = 1'b0;
        grant_d = 1'b0;
        fin_ack = 1'b0;
        fin_err = 1'b0;
        fin_to  = 1'b0;
        case (state)
            IDLE: begin
                if (i_ibus_cyc && (!i_dbus_cyc || last_d)) begin
                    grant_i = 1'b1;
                    state_d = GNT_I;
                end else if (i_dbus_cyc) begin
                    grant_d = 1'b1;
                    state_d = GNT_D;
                end
            end
            GNT_I, GNT_D: begin
                // ack beats err; err beats a coincident timeout
                if (i_wb_ack)      fin_ack = 1'b1;
                else if (i_wb_err) fin_err = 1'b1;
                else if (expired)  fin_to  = 1'b1;
                if (i_wb_ack || i_wb_err || expired) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign fin    = fin_ack || fin_err || fin_to;
    assign wd_clr = !(state_d == GNT_I || state_d == GNT_D);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            last_d     <= 1'b0;
            o_wb_adr   <= '0;
            o_wb_dat   <= '0;
            o_wb_sel   <= '0;
            o_wb_we    <= 1'b0;
            o_wb_cyc   <= 1'b0;
            o_wb_stb   <= 1'b0;
            rdt        <= '0;
            o_ibus_ack <= 1'b0;
            o_dbus_ack <= 1'b0;
            o_timeout  <= 1'b0;
            o_err_cnt  <= '0;
        end else begin
            o_ibus_ack <= 1'b0;
            o_dbus_ack <= 1'b0;
            o_timeout  <= 1'b0;
            if (grant_i) begin
                last_d   <= 1'b0;
                o_wb_adr <= i_ibus_adr;
                o_wb_dat <= '0;
                o_wb_sel <= 4'hF;
                o_wb_we  <= 1'b0;
                o_wb_cyc <= 1'b1;
                o_wb_stb <= 1'b1;
            end else if (grant_d) begin
                last_d   <= 1'b1;
                o_wb_adr <= i_dbus_adr;
                o_wb_dat <= i_dbus_dat;
                o_wb_sel <= i_dbus_sel;
                o_wb_we  <= i_dbus_we;
                o_wb_cyc <= 1'b1;
                o_wb_stb <= 1'b1;
            end
            if (fin) begin
                o_wb_cyc   <= 1'b0;
                o_wb_stb   <= 1'b0;
                rdt        <= fin_ack ? i_wb_rdt : ERR_RDT;
                o_ibus_ack <= (state == GNT_I);
                o_dbus_ack <= (state == GNT_D);
                o_timeout  <= fin_to;
                if (!fin_ack && o_err_cnt != 8'hFF)
                    o_err_cnt <= o_err_cnt + 8'd1;
            end
        end
    end

    assign o_ibus_rdt = rdt;
    assign o_dbus_rdt = rdt;
endmodule

// File: tb/tb_serv_bus_arbiter.sv
// Directed bench for serv_bus_arbiter: fetch, write, tie-break, timeout, errors, reset.
module tb_serv_bus_arbiter;
    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_ibus_adr = '0;
    logic        i_ibus_cyc = 1'b0;
    logic [31:0] o_ibus_rdt;
    logic        o_ibus_ack;
    logic [31:0] i_dbus_adr = '0;
    logic [31:0] i_dbus_dat = '0;
    logic [3:0]  i_dbus_sel = '0;
    logic        i_dbus_we = 1'b0;
    logic        i_dbus_cyc = 1'b0;
    logic [31:0] o_dbus_rdt;
    logic        o_dbus_ack;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic [31:0] i_wb_rdt = '0;
    logic        i_wb_ack = 1'b0;
    logic        i_wb_err = 1'b0;
    logic        o_timeout;
    logic [7:0]  o_err_cnt;

    int checks = 0;
    int errors = 0;

    serv_bus_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .i_rst(i_rst),
        .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc),
        .o_ibus_rdt(o_ibus_rdt), .o_ibus_ack(o_ibus_ack),
        .i_dbus_adr(i_dbus_adr), .i_dbus_dat(i_dbus_dat), .i_dbus_sel(i_dbus_sel),
        .i_dbus_we(i_dbus_we), .i_dbus_cyc(i_dbus_cyc),
        .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
        .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
        .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
        .o_timeout(o_timeout), .o_err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".wb_cyc"},   32'(o_wb_cyc),   32'd0);
        chk({tag, ".wb_stb"},   32'(o_wb_stb),   32'd0);
        chk({tag, ".wb_adr"},   o_wb_adr,        32'd0);
        chk({tag, ".wb_dat"},   o_wb_dat,        32'd0);
        chk({tag, ".wb_sel"},   32'(o_wb_sel),   32'd0);
        chk({tag, ".wb_we"},    32'(o_wb_we),    32'd0);
        chk({tag, ".ibus_ack"}, 32'(o_ibus_ack), 32'd0);
        chk({tag, ".dbus_ack"}, 32'(o_dbus_ack), 32'd0);
        chk({tag, ".ibus_rdt"}, o_ibus_rdt,      32'd0);
        chk({tag, ".dbus_rdt"}, o_dbus_rdt,      32'd0);
        chk({tag, ".timeout"},  32'(o_timeout),  32'd0);
        chk({tag, ".err_cnt"},  32'(o_err_cnt),  32'd0);
    endtask

    initial begin
        // reset state
        tick(); tick();
        chk_all_zero("rst");
        i_rst = 1'b0;
        tick();

        // ibus fetch, slave acks in the strobe cycle
        i_ibus_adr = 32'h0000_0080; i_ibus_cyc = 1'b1;
        tick();
        chk("if.cyc", 32'(o_wb_cyc), 32'd1);
        chk("if.stb", 32'(o_wb_stb), 32'd1);
        chk("if.adr", o_wb_adr, 32'h0000_0080);
        chk("if.we",  32'(o_wb_we), 32'd0);
        chk("if.sel", 32'(o_wb_sel), 32'hF);
        chk("if.dat", o_wb_dat, 32'd0);
        i_wb_ack = 1'b1; i_wb_rdt = 32'h0000_0013;
        tick();
        chk("if.ack",   32'(o_ibus_ack), 32'd1);
        chk("if.rdt",   o_ibus_rdt, 32'h0000_0013);
        chk("if.dack",  32'(o_dbus_ack), 32'd0);
        chk("if.cyc2",  32'(o_wb_cyc), 32'd0);
        i_wb_ack = 1'b0; i_wb_rdt = 32'hFFFF_FFFF;
        tick();
        i_ibus_cyc = 1'b0;
        chk("if.ack3",  32'(o_ibus_ack), 32'd0);
        chk("if.hold",  o_ibus_rdt, 32'h0000_0013);
        tick();

        // dbus write, three wait states
        i_dbus_adr = 32'h1000_0004; i_dbus_dat = 32'hCAFE_F00D;
        i_dbus_sel = 4'b0011; i_dbus_we = 1'b1; i_dbus_cyc = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("wr.cyc", 32'(o_wb_cyc), 32'd1);
            chk("wr.adr", o_wb_adr, 32'h1000_0004);
            chk("wr.dat", o_wb_dat, 32'hCAFE_F00D);
            chk("wr.sel", 32'(o_wb_sel), 32'h3);
            chk("wr.we",  32'(o_wb_we), 32'd1);
            chk("wr.ack_early", 32'(o_dbus_ack), 32'd0);
        end
        i_wb_ack = 1'b1;
        tick();
        chk("wr.ack",  32'(o_dbus_ack), 32'd1);
        chk("wr.iack", 32'(o_ibus_ack), 32'd0);
        chk("wr.cyc5", 32'(o_wb_cyc), 32'd0);
        i_wb_ack = 1'b0;
        tick();
        i_dbus_cyc = 1'b0; i_dbus_we = 1'b0;
        chk("wr.ack6", 32'(o_dbus_ack), 32'd0);
        tick();

        // tie out of reset: dbus first, then ibus, next tie dbus again
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_ibus_adr = 32'h0000_0200; i_ibus_cyc = 1'b1;
        i_dbus_adr = 32'h2000_0000; i_dbus_cyc = 1'b1;
        tick();
        chk("tie1.adr", o_wb_adr, 32'h2000_0000);
        i_wb_ack = 1'b1; i_wb_rdt = 32'h0000_00D1;
        tick();
        chk("tie1.dack", 32'(o_dbus_ack), 32'd1);
        chk("tie1.iack", 32'(o_ibus_ack), 32'd0);
        chk("tie1.rdt",  o_dbus_rdt, 32'h0000_00D1);
        i_wb_ack = 1'b0;
        tick();
        i_dbus_cyc = 1'b0;
        chk("tie1.cyc3", 32'(o_wb_cyc), 32'd0);
        tick();
        chk("tie2.cyc", 32'(o_wb_cyc), 32'd1);
        chk("tie2.adr", o_wb_adr, 32'h0000_0200);
        chk("tie2.we",  32'(o_wb_we), 32'd0);
        i_wb_ack = 1'b1; i_wb_rdt = 32'h1234_5678;
        tick();
        chk("tie2.iack", 32'(o_ibus_ack), 32'd1);
        chk("tie2.dack", 32'(o_dbus_ack), 32'd0);
        chk("tie2.rdt",  o_ibus_rdt, 32'h1234_5678);
        i_wb_ack = 1'b0;
        tick();
        i_dbus_cyc = 1'b1;
        tick();
        chk("tie3.adr", o_wb_adr, 32'h2000_0000);
        i_wb_ack = 1'b1; i_wb_rdt = 32'h5A5A_5A5A;
        tick();
        chk("tie3.dack", 32'(o_dbus_ack), 32'd1);
        i_wb_ack = 1'b0;
        tick();
        i_dbus_cyc = 1'b0; i_ibus_cyc = 1'b0;
        tick(); tick(); tick();

        // watchdog timeout with TIMEOUT=4
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_ibus_adr = 32'h0000_0300; i_ibus_cyc = 1'b1;
        i_wb_rdt = 32'h5A5A_5A5A;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("to.cyc", 32'(o_wb_cyc), 32'd1);
            chk("to.pulse_early", 32'(o_timeout), 32'd0);
        end
        tick();
        chk("to.pulse", 32'(o_timeout), 32'd1);
        chk("to.ack",   32'(o_ibus_ack), 32'd1);
        chk("to.cyc5",  32'(o_wb_cyc), 32'd0);
        chk("to.rdt",   o_ibus_rdt, 32'd0);
        chk("to.cnt",   32'(o_err_cnt), 32'd1);
        tick();
        i_ibus_cyc = 1'b0;
        chk("to.pulse6", 32'(o_timeout), 32'd0);
        tick();

        // slave error on dbus read
        i_dbus_adr = 32'h3000_0000; i_dbus_we = 1'b0; i_dbus_sel = 4'hF; i_dbus_cyc = 1'b1;
        tick();
        i_wb_err = 1'b1; i_wb_rdt = 32'hBAD0_BAD0;
        tick();
        chk("er.ack", 32'(o_dbus_ack), 32'd1);
        chk("er.rdt", o_dbus_rdt, 32'd0);
        chk("er.cnt", 32'(o_err_cnt), 32'd2);
        chk("er.to",  32'(o_timeout), 32'd0);
        i_wb_err = 1'b0; i_dbus_cyc = 1'b0;
        tick();

        // ack and err together: ack wins, no count
        i_dbus_cyc = 1'b1;
        tick();
        i_wb_ack = 1'b1; i_wb_err = 1'b1; i_wb_rdt = 32'h0000_0077;
        tick();
        chk("ae.ack", 32'(o_dbus_ack), 32'd1);
        chk("ae.rdt", o_dbus_rdt, 32'h0000_0077);
        chk("ae.cnt", 32'(o_err_cnt), 32'd2);
        i_wb_ack = 1'b0; i_wb_err = 1'b0; i_dbus_cyc = 1'b0;
        tick();

        // 300 consecutive errors saturate the counter
        for (int n = 0; n < 300; n++) begin
            i_dbus_cyc = 1'b1;
            tick();
            i_wb_err = 1'b1;
            tick();
            i_wb_err = 1'b0; i_dbus_cyc = 1'b0;
            tick();
            if (n == 251) chk("sat.254", 32'(o_err_cnt), 32'd254);
        end
        chk("sat.255", 32'(o_err_cnt), 32'd255);

        // reset during GNT_D with slave ack pending
        i_dbus_adr = 32'h4000_0000; i_dbus_dat = 32'h1111_2222; i_dbus_we = 1'b1; i_dbus_cyc = 1'b1;
        tick();
        chk("mr.cyc", 32'(o_wb_cyc), 32'd1);
        i_rst = 1'b1; i_wb_ack = 1'b1; i_wb_rdt = 32'h9999_9999;
        tick();
        chk_all_zero("mr");
        i_rst = 1'b0; i_wb_ack = 1'b0; i_dbus_cyc = 1'b0;
        tick();
        chk("mr.dack", 32'(o_dbus_ack), 32'd0);
        chk("mr.cyc3", 32'(o_wb_cyc), 32'd0);
        i_ibus_adr = 32'h0000_0400; i_ibus_cyc = 1'b1;
        tick();
        chk("mr.fcyc", 32'(o_wb_cyc), 32'd1);
        chk("mr.fadr", o_wb_adr, 32'h0000_0400);
        i_wb_ack = 1'b1; i_wb_rdt = 32'h0000_0093;
        tick();
        chk("mr.fack", 32'(o_ibus_ack), 32'd1);
        chk("mr.frdt", o_ibus_rdt, 32'h0000_0093);
        i_wb_ack = 1'b0;
        tick();
        i_ibus_cyc = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
